// File: rtl/sprite_pkg.sv
// Shared types and screen defaults for sprite-movement blocks.
package sprite_pkg;

    typedef enum logic [2:0] {IDLE, UP, DOWN, LEFT, RIGHT} dirState_t;

    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;

endpackage

// File: rtl/sprite_mover_if.sv
// Button/scan/position bundle between a sprite mover and its driver.
interface sprite_mover_if #(
    parameter int X_W = 10,
    parameter int Y_W = 9
);
    logic           up;
    logic           down;
    logic           left;
    logic           right;
    logic           update;
    logic [X_W-1:0] xLength;
    logic [Y_W-1:0] yLength;
    logic           hit;
    logic [X_W-1:0] pos_x;
    logic [Y_W-1:0] pos_y;
    logic           moving;

    modport master (
        output up, down, left, right, update, xLength, yLength,
        input  hit, pos_x, pos_y, moving
    );

    modport slave (
        input  up, down, left, right, update, xLength, yLength,
        output hit, pos_x, pos_y, moving
    );
endinterface

// File: rtl/sprite_mover_rise_pulse.sv
// rise_pulse: one-cycle pulse on each rising edge of a level strobe.
module rise_pulse (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic pulse
);
    logic sigD;
    logic armed;

    // armed stays low for the first cycle after reset so an edge that arrived during reset is dropped
    always_ff @(posedge clk) begin
        if (!rst) begin
            sigD  <= 1'b0;
            armed <= 1'b0;
        end else begin
            sigD  <= sig;
            armed <= 1'b1;
        end
    end

    assign pulse = sig & ~sigD & armed;
endmodule

// File: rtl/sprite_mover.sv
// Button-driven sprite position with registered scan hit test.
// Define WRAP_ALL_EN to wrap at screen edges instead of clamping.
module sprite_mover
    import sprite_pkg::*;
#(
    parameter int SIZE     = 15,
    parameter int STEP     = 3,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int START_X  = 305,
    parameter int START_Y  = 200,
    parameter int X_W      = 10,
    parameter int Y_W      = 9
) (
    input logic           clk,
    input logic           rst,
    sprite_mover_if.slave bus
);
    logic           tick;
    dirState_t      state, nextState;
    logic [X_W-1:0] posX, nextX;
    logic [Y_W-1:0] posY, nextY;
    logic           hitQ, hitNow;

    rise_pulse uTick (
        .clk   (clk),
        .rst   (rst),
        .sig   (bus.update),
        .pulse (tick)
    );

    // One spare bit keeps a step below zero negative instead of wrapping
    function automatic logic [X_W-1:0] moveX(input logic [X_W-1:0] p, input logic neg);
        logic signed [X_W:0] s, maxV;
        maxV = $signed((X_W+1)'(SCREEN_W - SIZE));
        s    = neg ? $signed({1'b0, p}) - $signed((X_W+1)'(STEP))
                   : $signed({1'b0, p}) + $signed((X_W+1)'(STEP));
`ifdef WRAP_ALL_EN
        if (s < 0)    return (p == '0) ? maxV[X_W-1:0] : '0;
        if (s > maxV) return (p == maxV[X_W-1:0]) ? '0 : maxV[X_W-1:0];
`else
        if (s < 0)    return '0;
        if (s > maxV) return maxV[X_W-1:0];
`endif
        return s[X_W-1:0];
    endfunction

    function automatic logic [Y_W-1:0] moveY(input logic [Y_W-1:0] p, input logic neg);
        logic signed [Y_W:0] s, maxV;
        maxV = $signed((Y_W+1)'(SCREEN_H - SIZE));
        s    = neg ? $signed({1'b0, p}) - $signed((Y_W+1)'(STEP))
                   : $signed({1'b0, p}) + $signed((Y_W+1)'(STEP));
`ifdef WRAP_ALL_EN
        if (s < 0)    return (p == '0) ? maxV[Y_W-1:0] : '0;
        if (s > maxV) return (p == maxV[Y_W-1:0]) ? '0 : maxV[Y_W-1:0];
`else
        if (s < 0)    return '0;
        if (s > maxV) return maxV[Y_W-1:0];
`endif
        return s[Y_W-1:0];
    endfunction

    // A move state steps only while its button is still held; the release tick just returns to IDLE
    always_comb begin
        nextState = state;
        nextX     = posX;
        nextY     = posY;
        if (tick) begin
            unique case (state)
                IDLE: begin
                    if (!bus.up)         nextState = UP;
                    else if (!bus.down)  nextState = DOWN;
                    else if (!bus.left)  nextState = LEFT;
                    else if (!bus.right) nextState = RIGHT;
                end
                UP:    if (!bus.up)    nextY = moveY(posY, 1'b1); else nextState = IDLE;
                DOWN:  if (!bus.down)  nextY = moveY(posY, 1'b0); else nextState = IDLE;
                LEFT:  if (!bus.left)  nextX = moveX(posX, 1'b1); else nextState = IDLE;
                RIGHT: if (!bus.right) nextX = moveX(posX, 1'b0); else nextState = IDLE;
                default: nextState = IDLE;
            endcase
        end
    end

    always_comb begin
        hitNow = ({1'b0, bus.xLength} >= {1'b0, posX}) &&
                 ({1'b0, bus.xLength} <  {1'b0, posX} + (X_W+1)'(SIZE)) &&
                 ({1'b0, bus.yLength} >= {1'b0, posY}) &&
                 ({1'b0, bus.yLength} <  {1'b0, posY} + (Y_W+1)'(SIZE));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            posX  <= X_W'(START_X);
            posY  <= Y_W'(START_Y);
            hitQ  <= 1'b0;
        end else begin
            state <= nextState;
            posX  <= nextX;
            posY  <= nextY;
            hitQ  <= hitNow;
        end
    end

    assign bus.pos_x  = posX;
    assign bus.pos_y  = posY;
    assign bus.hit    = hitQ;
    assign bus.moving = (state != IDLE);
endmodule

// File: tb/tb_sprite_mover.sv
// Self-checking bench for sprite_mover: directed sequences, hit table, random run vs. model.
module tb_sprite_mover;
    localparam int SIZE = 15, STEP = 3, SW = 640, SH = 480;
    localparam int SX = 305, SY = 200;
    localparam int XMAX = SW - SIZE, YMAX = SH - SIZE;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sprite_mover_if #(.X_W(10), .Y_W(9)) bus ();

    sprite_mover dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: dir 0=idle 1=up 2=down 3=left 4=right
    int mx, my, mdir;
    bit mhit, mprevUpd, mfreshReset;

    function automatic int clampi(int v, int lo, int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic bit held(int dir);
        case (dir)
            1: return !bus.up;
            2: return !bus.down;
            3: return !bus.left;
            4: return !bus.right;
            default: return 1'b0;
        endcase
    endfunction

    task automatic modelStep();
        bit tick;
        if (!rst) begin
            mdir = 0; mx = SX; my = SY; mhit = 0; mprevUpd = 0; mfreshReset = 1;
        end else begin
            tick = bus.update && !mprevUpd && !mfreshReset;
            mhit = (int'(bus.xLength) >= mx) && (int'(bus.xLength) < mx + SIZE) &&
                   (int'(bus.yLength) >= my) && (int'(bus.yLength) < my + SIZE);
            if (tick) begin
                if (mdir == 0) begin
                    if (!bus.up) mdir = 1;
                    else if (!bus.down) mdir = 2;
                    else if (!bus.left) mdir = 3;
                    else if (!bus.right) mdir = 4;
                end else if (held(mdir)) begin
                    case (mdir)
                        1: my = clampi(my - STEP, 0, YMAX);
                        2: my = clampi(my + STEP, 0, YMAX);
                        3: mx = clampi(mx - STEP, 0, XMAX);
                        default: mx = clampi(mx + STEP, 0, XMAX);
                    endcase
                end else begin
                    mdir = 0;
                end
            end
            mprevUpd = bus.update;
            mfreshReset = 0;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        modelStep();
        #1;
        chk("model_pos_x", int'(bus.pos_x), mx);
        chk("model_pos_y", int'(bus.pos_y), my);
        chk("model_hit", int'(bus.hit), int'(mhit));
        chk("model_moving", int'(bus.moving), int'(mdir != 0));
    endtask

    task automatic doTick();
        bus.update = 1'b1; cyc();
        bus.update = 1'b0; cyc();
    endtask

    task automatic releaseAll();
        bus.up = 1'b1; bus.down = 1'b1; bus.left = 1'b1; bus.right = 1'b1;
    endtask

    task automatic doReset();
        rst = 1'b0; bus.update = 1'b0; releaseAll();
        cyc(); cyc();
        rst = 1'b1; cyc();
    endtask

    typedef struct {
        int x;
        int y;
        bit expHit;
    } hitVec_t;

    hitVec_t hitTab[7];

    initial begin
        hitTab[0] = '{305, 200, 1'b1};
        hitTab[1] = '{319, 214, 1'b1};
        hitTab[2] = '{320, 214, 1'b0};
        hitTab[3] = '{304, 200, 1'b0};
        hitTab[4] = '{305, 199, 1'b0};
        hitTab[5] = '{319, 215, 1'b0};
        hitTab[6] = '{312, 207, 1'b1};

        releaseAll();
        bus.update = 1'b0; bus.xLength = '0; bus.yLength = '0;
        mx = SX; my = SY; mdir = 0; mhit = 0; mprevUpd = 0; mfreshReset = 1;

        // Reset state
        rst = 1'b0; cyc(); cyc();
        chk("reset_pos_x", int'(bus.pos_x), 305);
        chk("reset_pos_y", int'(bus.pos_y), 200);
        chk("reset_hit", int'(bus.hit), 0);
        chk("reset_moving", int'(bus.moving), 0);
        rst = 1'b1; cyc();

        // Hit boundary table
        foreach (hitTab[i]) begin
            bus.xLength = 10'(hitTab[i].x);
            bus.yLength = 9'(hitTab[i].y);
            cyc();
            chk($sformatf("hit_tab%0d", i), int'(bus.hit), int'(hitTab[i].expHit));
        end

        // Right held three ticks, then release
        bus.right = 1'b0;
        doTick();
        chk("right_enter_moving", int'(bus.moving), 1);
        chk("right_enter_x", int'(bus.pos_x), 305);
        doTick(); chk("right_t2_x", int'(bus.pos_x), 308);
        doTick(); chk("right_t3_x", int'(bus.pos_x), 311);
        bus.right = 1'b1;
        doTick();
        chk("right_rel_moving", int'(bus.moving), 0);
        chk("right_rel_x", int'(bus.pos_x), 311);
        // Between ticks nothing moves
        bus.left = 1'b0; cyc(); cyc(); cyc();
        chk("hold_moving", int'(bus.moving), 0);
        chk("hold_x", int'(bus.pos_x), 311);

        // Right clamp at SCREEN_W-SIZE
        doReset();
        bus.right = 1'b0;
        doTick();
        for (int k = 0; k < 106; k++) doTick();
        chk("clamp_pre_x", int'(bus.pos_x), 623);
        doTick(); chk("clamp_t1_x", int'(bus.pos_x), 625);
        doTick(); chk("clamp_t2_x", int'(bus.pos_x), 625);
        chk("clamp_moving", int'(bus.moving), 1);

        // Priority up over left
        doReset();
        bus.up = 1'b0; bus.left = 1'b0;
        doTick();
        chk("prio_moving", int'(bus.moving), 1);
        chk("prio_t1_y", int'(bus.pos_y), 200);
        doTick();
        chk("prio_t2_y", int'(bus.pos_y), 197);
        chk("prio_t2_x", int'(bus.pos_x), 305);

        // Reset while moving down with update held high
        doReset();
        bus.down = 1'b0;
        doTick(); doTick();
        chk("rstmid_pre_y", int'(bus.pos_y), 203);
        bus.update = 1'b1;
        rst = 1'b0; cyc(); cyc();
        chk("rstmid_moving", int'(bus.moving), 0);
        chk("rstmid_y", int'(bus.pos_y), 200);
        rst = 1'b1; cyc(); cyc();
        chk("rstmid_notick_moving", int'(bus.moving), 0);
        chk("rstmid_notick_y", int'(bus.pos_y), 200);
        bus.update = 1'b0; cyc();

        // Randomised run against the model
        releaseAll();
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                bus.up    = ($urandom_range(0, 3) != 0);
                bus.down  = ($urandom_range(0, 3) != 0);
                bus.left  = ($urandom_range(0, 3) != 0);
                bus.right = ($urandom_range(0, 3) != 0);
            end
            bus.update  = $urandom_range(0, 1);
            rst         = ($urandom_range(0, 299) != 0);
            bus.xLength = 10'(clampi(mx + $urandom_range(0, 22) - 4, 0, SW - 1));
            bus.yLength = 9'(clampi(my + $urandom_range(0, 22) - 4, 0, SH - 1));
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
